regfile_dump: RTL and testbench

- Read-side companion to the 32x32 register bank.
- On a start pulse, walks every register through the bank's asynchronous debug read port (`addrout`/`regout`).
- Streams each word out over a valid/ready interface for the debug/trace path.
- Lets the bench and the board debug link dump full architectural state without stalling the pipeline's A/B read ports.

---
 rtl/regfile_dump.sv | 117 +++++++++++
 tb/tb_regfile_dump.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks the register bank debug port and streams each word over valid/ready.
// Optional trailing XOR checksum word when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addrout,
    input  logic [DATA_W-1:0] regout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd4;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] index;
    logic              handshake;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign handshake = out_valid & out_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    // The bank port is only meaningful during READ; park it at 0 otherwise.
    assign addrout   = (state == S_READ) ? index : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            index     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_READ;
                        index <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                S_READ: begin
                    out_data  <= regout;
                    out_addr  <= index;
                    out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= (index == LAST_IDX);
`endif
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (handshake) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum <= csum ^ out_data;
`endif
                        if (index == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            // Checksum word follows directly, folding in the word just accepted.
                            out_valid <= 1'b1;
                            out_data  <= csum ^ out_data;
                            out_addr  <= '0;
                            out_last  <= 1'b1;
                            state     <= S_CSUM;
`else
                            out_valid <= 1'b0;
                            state     <= S_DONE;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            index     <= index + ADDR_W'(1);
                            state     <= S_READ;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed table-driven bench for regfile_dump with a behavioural register bank.
module tb_regfile_dump;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int NW       = NUM_REGS + 1;
    localparam int DONE_CYC = 2 * NUM_REGS + 2;
    localparam bit CSUM_ON  = 1'b1;
`else
    localparam int NW       = NUM_REGS;
    localparam int DONE_CYC = 2 * NUM_REGS + 1;
    localparam bit CSUM_ON  = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addrout;
    logic [DATA_W-1:0] regout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    logic [DATA_W-1:0] bank [NUM_REGS];
    logic [DATA_W-1:0] expv [NUM_REGS];

    int checks = 0;
    int fails  = 0;

    assign regout = bank[addrout];

    regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .addrout(addrout), .regout(regout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] base;
        int          mode;        // 0 ready high, 1 toggle, 2 toggle + 10-cycle stall
        int          restart_at;  // word index at which start is pulsed again, -1 none
        int          stall_word;
        bit          poke3;
        logic [31:0] exp_csum;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [31:0] base, input bit poke3);
        for (int i = 0; i < NUM_REGS; i++) begin
            bank[i] = base + 32'(i);
            expv[i] = base + 32'(i);
        end
        if (poke3) begin
            bank[3] = 32'hFFFF_FFFF;
            expv[3] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic run_dump(input vec_t v);
        int cyc, nwords, ndone, done_cyc, busy_cyc, stall_left;
        bit restarted, hold;
        logic [DATA_W+ADDR_W:0] held;
        cyc = 1; nwords = 0; ndone = 0; done_cyc = 0; busy_cyc = 0;
        stall_left = 10; restarted = 0; hold = 0; held = '0;
        preload(v.base, v.poke3);
        start = 1'b1;
        out_ready = (v.mode == 0);
        tick();
        start = 1'b0;
        while (cyc < 600) begin
            if (done) begin ndone++; done_cyc = cyc; end
            if (busy) busy_cyc++;
            if (hold)
                check("stall_hold", {out_valid, out_last, out_addr, out_data}, {1'b1, held});
            case (v.mode)
                0: out_ready = 1'b1;
                1: out_ready = cyc[0];
                default: begin
                    if (out_valid && nwords == v.stall_word && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = cyc[0];
                    end
                end
            endcase
            if (v.restart_at >= 0 && !restarted && out_valid && nwords == v.restart_at) begin
                start = 1'b1;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (nwords < NUM_REGS) begin
                    check("word_addr", out_addr, nwords);
                    check("word_data", out_data, expv[nwords]);
                    check("word_last", out_last, (nwords == NUM_REGS - 1) && !CSUM_ON);
                end else if (nwords < NW) begin
                    check("csum_data", out_data, v.exp_csum);
                    check("csum_addr", out_addr, 0);
                    check("csum_last", out_last, 1);
                end else begin
                    check("extra_word", nwords, NW - 1);
                end
                nwords++;
            end
            hold = out_valid && !out_ready;
            held = {out_last, out_addr, out_data};
            if (!busy) break;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("dump_terminated", cyc < 600, 1);
        check("word_count", nwords, NW);
        check("done_count", ndone, 1);
        check("busy_span", busy_cyc, done_cyc);
        if (v.mode == 0) check("done_cycle", done_cyc, DONE_CYC);
        if (v.mode == 2) check("stall_used", stall_left, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{base: 32'h1000_0000, mode: 0, restart_at: -1, stall_word: -1, poke3: 0, exp_csum: 32'h0};
        tbl[1] = '{base: 32'h1000_0000, mode: 2, restart_at: -1, stall_word: 5,  poke3: 0, exp_csum: 32'h0};
        tbl[2] = '{base: 32'h1000_0000, mode: 0, restart_at: 10, stall_word: -1, poke3: 0, exp_csum: 32'h0};
        tbl[3] = '{base: 32'h0000_0000, mode: 1, restart_at: -1, stall_word: -1, poke3: 0, exp_csum: 32'h0};
        tbl[4] = '{base: 32'h0000_0000, mode: 0, restart_at: -1, stall_word: -1, poke3: 1, exp_csum: 32'hFFFF_FFFC};

        reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        preload(32'h1000_0000, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_outs", {busy, done, out_valid, out_last}, 4'b0);
            check("rst_addrout", addrout, 0);
            check("rst_word", {out_addr, out_data}, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_outs", {busy, done, out_valid, addrout}, 0);
        end

        for (int t = 0; t < 5; t++) run_dump(tbl[t]);

        preload(32'h1000_0000, 0);
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_addr == 5'd20) && n < 200) begin
            tick();
            n++;
        end
        check("reach_word20", n < 200, 1);
        check("word20_data", out_data, 32'h1000_0014);
        out_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_outs", {out_valid, busy, done}, 3'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_nodone", {done, busy, out_valid}, 3'b0);
        end
        run_dump(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
